rtype_multicycle_ctrl: RTL and testbench



---
 rtl/rtype_multicycle_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rtype_multicycle_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtype_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for an R-type MIPS datapath.
// Drives imem/register-bank addresses, ALU control and write enable; counts retired instructions.
module rtype_multicycle_ctrl #(
    parameter int AW       = 8,
    parameter int PROG_LEN = 16
) (
    input  logic          clk_CPU,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_data,
    input  logic          imem_valid,
    output logic [4:0]    rs_addr,
    output logic [4:0]    rt_addr,
    output logic [4:0]    rd_addr,
    output logic          rb_we,
    output logic [3:0]    alu_op,
    output logic          busy,
    output logic          halted,
    output logic          illegal,
    output logic [15:0]   instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_PC = AW'(PROG_LEN - 1);

    // Returns {legal, alu_op}; legal only for opcode 0 with a supported funct.
    function automatic logic [4:0] decode_rtype(input logic [31:0] ir);
        logic [4:0] res;
        res = 5'b0_0000;
        if (ir[31:26] == 6'b00_0000) begin
            case (ir[5:0])
                6'b10_0000: res = 5'b1_0010;
                6'b10_0010: res = 5'b1_0110;
                6'b10_0100: res = 5'b1_0000;
                6'b10_0101: res = 5'b1_0001;
                6'b10_1010: res = 5'b1_0111;
                6'b10_0111: res = 5'b1_1100;
                default:    res = 5'b0_0000;
            endcase
        end else begin
            res = 5'b0_0000;
        end
        return res;
    endfunction

    state_t         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [31:0]    ir_q, ir_d;
    logic [3:0]     alu_op_q, alu_op_d;
    logic           rb_we_q, rb_we_d;
    logic           busy_q, busy_d;
    logic           halted_q, halted_d;
    logic           illegal_q, illegal_d;
    logic [15:0]    count_q, count_d;
    logic [4:0]     dec_s;

    // Next-state and next-output logic for the instruction sequencer.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_op_d  = 4'b0000;
        rb_we_d   = 1'b0;
        illegal_d = illegal_q;
        count_d   = count_q;
        dec_s     = decode_rtype(ir_q);

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = {AW{1'b0}};
                    illegal_d = 1'b0;
                    count_d   = 16'h0000;
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (dec_s[4]) begin
                    state_d  = S_EXEC;
                    alu_op_d = dec_s[3:0];
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                state_d  = S_WB;
                alu_op_d = alu_op_q;
                // $zero is hard-wired, so a write to it is suppressed.
                rb_we_d  = (ir_q[15:11] != 5'd0);
            end
            S_WB: begin
                count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                if (pc_q == LAST_PC) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                   (state_d == S_EXEC)  || (state_d == S_WB);
        halted_d = (state_d == S_HALT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_CPU) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= {AW{1'b0}};
            ir_q      <= 32'h0000_0000;
            alu_op_q  <= 4'b0000;
            rb_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_op_q  <= alu_op_d;
            rb_we_q   <= rb_we_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign rs_addr     = ir_q[25:21];
    assign rt_addr     = ir_q[20:16];
    assign rd_addr     = ir_q[15:11];
    assign rb_we       = rb_we_q;
    assign alu_op      = alu_op_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_rtype_multicycle_ctrl.sv
// Directed bench for rtype_multicycle_ctrl (AW=8, PROG_LEN=3).
// Inputs change and outputs are sampled on the falling edge of clk_CPU.
module tb_rtype_multicycle_ctrl;

    logic        clk_CPU;
    logic        rst_n;
    logic        start;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        rb_we;
    logic [3:0]  alu_op;
    logic        busy, halted, illegal;
    logic [15:0] instr_count;

    logic [31:0] mem [0:255];
    int total;
    int bad;

    rtype_multicycle_ctrl #(.AW(8), .PROG_LEN(3)) dut (
        .clk_CPU    (clk_CPU),
        .rst_n      (rst_n),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rd_addr    (rd_addr),
        .rb_we      (rb_we),
        .alu_op     (alu_op),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal),
        .instr_count(instr_count)
    );

    assign imem_data = mem[imem_addr];

    initial begin
        clk_CPU = 1'b0;
        forever #5 clk_CPU = ~clk_CPU;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] r_instr(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic load_legal3();
        mem[0] = r_instr(5'd1, 5'd2, 5'd3, 6'h20);
        mem[1] = r_instr(5'd3, 5'd1, 5'd4, 6'h22);
        mem[2] = r_instr(5'd1, 5'd2, 5'd5, 6'h25);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk_CPU);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int max_cycles);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < max_cycles) begin
            @(negedge clk_CPU);
            n++;
        end
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL wait_halt got halted=%b after %0d cycles, want 1", halted, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        imem_valid = 1'b1;
        @(negedge clk_CPU);
        @(negedge clk_CPU);
        total++;
        if ({busy, halted, illegal, rb_we} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {busy, halted, illegal, rb_we});
        end
        total++;
        if ({imem_addr, alu_op, instr_count} !== 28'h0) begin
            bad++;
            $display("FAIL reset_vals got addr=%h op=%h cnt=%h want 0", imem_addr, alu_op, instr_count);
        end
        total++;
        if ({rs_addr, rt_addr, rd_addr} !== 15'h0) begin
            bad++;
            $display("FAIL reset_regaddr got=%h want=0", {rs_addr, rt_addr, rd_addr});
        end
        rst_n = 1'b1;
        @(negedge clk_CPU);
    endtask

    task automatic test_program();
        logic [3:0] exp_op [3];
        logic [4:0] exp_rd [3];
        int i;
        int ph;
        exp_op = '{4'b0010, 4'b0110, 4'b0001};
        exp_rd = '{5'd3, 5'd4, 5'd5};
        load_legal3();
        imem_valid = 1'b1;
        do_start();
        for (int c = 0; c < 12; c++) begin
            i  = c / 4;
            ph = c % 4;
            total++;
            if ({busy, halted} !== 2'b10) begin
                bad++;
                $display("FAIL prog_busy c=%0d got busy/halted=%b want 10", c, {busy, halted});
            end
            total++;
            if (rb_we !== (ph == 3)) begin
                bad++;
                $display("FAIL prog_we c=%0d got=%b want=%b", c, rb_we, (ph == 3));
            end
            total++;
            if (alu_op !== ((ph >= 2) ? exp_op[i] : 4'b0000)) begin
                bad++;
                $display("FAIL prog_aluop c=%0d got=%b want=%b", c, alu_op,
                         (ph >= 2) ? exp_op[i] : 4'b0000);
            end
            if (ph == 0) begin
                total++;
                if (imem_addr !== 8'(i)) begin
                    bad++;
                    $display("FAIL prog_addr c=%0d got=%0d want=%0d", c, imem_addr, i);
                end
            end
            if (ph == 3) begin
                total++;
                if (rd_addr !== exp_rd[i]) begin
                    bad++;
                    $display("FAIL prog_rd c=%0d got=%0d want=%0d", c, rd_addr, exp_rd[i]);
                end
            end
            if (c == 6) begin
                total++;
                if ({rs_addr, rt_addr} !== {5'd3, 5'd1}) begin
                    bad++;
                    $display("FAIL prog_rsrt got rs=%0d rt=%0d want 3 1", rs_addr, rt_addr);
                end
            end
            @(negedge clk_CPU);
        end
        total++;
        if ({busy, halted, illegal} !== 3'b010) begin
            bad++;
            $display("FAIL prog_halt got busy/halted/illegal=%b want 010", {busy, halted, illegal});
        end
        total++;
        if (instr_count !== 16'd3 || imem_addr !== 8'd2) begin
            bad++;
            $display("FAIL prog_count got cnt=%0d addr=%0d want 3 2", instr_count, imem_addr);
        end
    endtask

    task automatic test_illegal();
        mem[0] = r_instr(5'd1, 5'd2, 5'd3, 6'h20);
        mem[1] = 32'h8C22_0000;
        do_start();
        for (int c = 0; c < 6; c++) begin
            total++;
            if (rb_we !== (c == 3)) begin
                bad++;
                $display("FAIL ill_we c=%0d got=%b want=%b", c, rb_we, (c == 3));
            end
            @(negedge clk_CPU);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({busy, halted, illegal, rb_we} !== 4'b0110) begin
                bad++;
                $display("FAIL ill_flags k=%0d got=%b want=0110", k, {busy, halted, illegal, rb_we});
            end
            total++;
            if (imem_addr !== 8'd1 || instr_count !== 16'd1) begin
                bad++;
                $display("FAIL ill_pc k=%0d got addr=%0d cnt=%0d want 1 1", k, imem_addr, instr_count);
            end
            @(negedge clk_CPU);
        end
    endtask

    task automatic test_zero_rd();
        mem[0] = r_instr(5'd1, 5'd2, 5'd0, 6'h20);
        mem[1] = r_instr(5'd1, 5'd2, 5'd3, 6'h20);
        mem[2] = r_instr(5'd1, 5'd2, 5'd5, 6'h25);
        do_start();
        total++;
        if ({illegal, halted, busy} !== 3'b001 || instr_count !== 16'd0 || imem_addr !== 8'd0) begin
            bad++;
            $display("FAIL restart got ill/halt/busy=%b cnt=%0d addr=%0d want 001 0 0",
                     {illegal, halted, busy}, instr_count, imem_addr);
        end
        repeat (3) @(negedge clk_CPU);
        total++;
        if (rb_we !== 1'b0 || alu_op !== 4'b0010 || rd_addr !== 5'd0) begin
            bad++;
            $display("FAIL zero_wb got we=%b op=%b rd=%0d want 0 0010 0", rb_we, alu_op, rd_addr);
        end
        @(negedge clk_CPU);
        total++;
        if (instr_count !== 16'd1 || imem_addr !== 8'd1) begin
            bad++;
            $display("FAIL zero_retire got cnt=%0d addr=%0d want 1 1", instr_count, imem_addr);
        end
        wait_halt(20);
        total++;
        if (instr_count !== 16'd3) begin
            bad++;
            $display("FAIL zero_count got=%0d want=3", instr_count);
        end
    endtask

    task automatic test_stall();
        load_legal3();
        do_start();
        repeat (3) @(negedge clk_CPU);
        imem_valid = 1'b0;
        @(negedge clk_CPU);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (imem_addr !== 8'd1 || {busy, rb_we} !== 2'b10 || alu_op !== 4'b0000) begin
                bad++;
                $display("FAIL stall k=%0d got addr=%0d busy/we=%b op=%b want 1 10 0000",
                         k, imem_addr, {busy, rb_we}, alu_op);
            end
            if (k == 2) start = 1'b1;
            else        start = 1'b0;
            @(negedge clk_CPU);
        end
        imem_valid = 1'b1;
        @(negedge clk_CPU);
        @(negedge clk_CPU);
        total++;
        if (alu_op !== 4'b0110 || rb_we !== 1'b0) begin
            bad++;
            $display("FAIL stall_exec got op=%b we=%b want 0110 0", alu_op, rb_we);
        end
        @(negedge clk_CPU);
        total++;
        if (rb_we !== 1'b1 || rd_addr !== 5'd4) begin
            bad++;
            $display("FAIL stall_wb got we=%b rd=%0d want 1 4", rb_we, rd_addr);
        end
        @(negedge clk_CPU);
        total++;
        if (instr_count !== 16'd2 || imem_addr !== 8'd2) begin
            bad++;
            $display("FAIL stall_resume got cnt=%0d addr=%0d want 2 2", instr_count, imem_addr);
        end
        wait_halt(20);
        total++;
        if (instr_count !== 16'd3 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL stall_end got cnt=%0d ill=%b want 3 0", instr_count, illegal);
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        repeat (6) @(negedge clk_CPU);
        total++;
        if (alu_op !== 4'b0110 || imem_addr !== 8'd1) begin
            bad++;
            $display("FAIL mid_exec got op=%b addr=%0d want 0110 1", alu_op, imem_addr);
        end
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk_CPU);
        total++;
        if ({busy, halted, illegal, rb_we} !== 4'b0000 || alu_op !== 4'b0000) begin
            bad++;
            $display("FAIL mid_rst_flags got=%b op=%b want 0000 0000", {busy, halted, illegal, rb_we}, alu_op);
        end
        total++;
        if (imem_addr !== 8'd0 || instr_count !== 16'd0 || rd_addr !== 5'd0) begin
            bad++;
            $display("FAIL mid_rst_vals got addr=%0d cnt=%0d rd=%0d want 0 0 0", imem_addr, instr_count, rd_addr);
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk_CPU);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_idle got busy=%b want 0", busy);
        end
        do_start();
        total++;
        if (busy !== 1'b1 || imem_addr !== 8'd0) begin
            bad++;
            $display("FAIL mid_rerun got busy=%b addr=%0d want 1 0", busy, imem_addr);
        end
        wait_halt(20);
        total++;
        if (instr_count !== 16'd3) begin
            bad++;
            $display("FAIL mid_count got=%0d want=3", instr_count);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int a = 0; a < 256; a++) mem[a] = 32'h0000_0000;
        rst_n = 1'b0;
        start = 1'b0;
        imem_valid = 1'b1;
        test_reset();
        test_program();
        test_illegal();
        test_zero_rd();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
